vram_scanout: RTL and testbench

//  Read side of the 128x64x2bpp VRAM written by the CPU. Generates VGA timing and scans VRAM.

---
 rtl/vram_scanout.sv | 195 +++++++++++++++++++
 tb/tb_vram_scanout.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vram_scanout.sv
// vram_scanout: read side of the 2bpp VRAM. Generates VGA timing, scans the
// image with integer pixel replication (no dividers), maps 2-bit pixels to
// 12-bit grey and emits a one-clk tick at the start of vertical blank.
// Ports:
//   clk          pixel clock, all logic on the rising edge
//   reset_n      synchronous active-low reset
//   vram_hpos    VRAM read column (0 outside the image window)
//   vram_vpos    VRAM read row    (0 outside the image window)
//   vram_pixelo  VRAM read data, valid one clk after the address
//   vga_hsync    horizontal sync, active low
//   vga_vsync    vertical sync, active low
//   vga_de       high during the visible area
//   vga_rgb      {R,G,B} 4 bits each
//   frame_tick   one-clk pulse at the start of vertical blank
module vram_scanout #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SCALE_X  = 5,
  parameter int unsigned SCALE_Y  = 7,
  parameter int unsigned X_OFF    = 0,
  parameter int unsigned Y_OFF    = 16,
  parameter int unsigned IMG_W    = 128,
  parameter int unsigned IMG_H    = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [6:0]  vram_hpos,
  output logic [5:0]  vram_vpos,
  input  logic [1:0]  vram_pixelo,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_de,
  output logic [11:0] vga_rgb,
  output logic        frame_tick
);

  localparam int unsigned CW = 10;
  localparam int unsigned SW = 4;
  localparam int unsigned XW = 7;
  localparam int unsigned YW = 6;

  localparam logic [CW-1:0] H_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] X_BEG   = CW'(X_OFF);
  localparam logic [CW-1:0] X_LEN   = CW'(IMG_W * SCALE_X);
  localparam logic [CW-1:0] Y_BEG   = CW'(Y_OFF);
  localparam logic [CW-1:0] Y_LEN   = CW'(IMG_H * SCALE_Y);
  localparam logic [SW-1:0] SX_LAST = SW'(SCALE_X - 1);
  localparam logic [SW-1:0] SY_LAST = SW'(SCALE_Y - 1);

  // stage 0 state
  logic [CW-1:0] h_cnt, v_cnt;
  logic [SW-1:0] sx, sy;
  logic [XW-1:0] xpix;
  logic [YW-1:0] ypix;

  // stage 1 timing
  logic s1_hs, s1_vs, s1_de, s1_img, s1_tick;

  // next-state and decode
  logic [CW-1:0] h_nxt, v_nxt;
  logic [SW-1:0] sx_nxt, sy_nxt;
  logic [XW-1:0] xpix_nxt, hpos_nxt;
  logic [YW-1:0] ypix_nxt, vpos_nxt;
  logic          h_wrap, v_wrap;
  logic          h_in, v_in, h_in_nxt, v_in_nxt;
  logic          s0_hs, s0_vs, s0_de, s0_img, s0_tick;
  logic [11:0]   pal_c;

  // Window tests use a wrapping subtraction so positions left of/above the
  // offset land far beyond the window length.
  always_comb begin
    h_wrap   = (h_cnt == H_LAST);
    v_wrap   = (v_cnt == V_LAST);
    h_nxt    = h_wrap ? '0 : h_cnt + CW'(1);
    v_nxt    = v_cnt;
    if (h_wrap) v_nxt = v_wrap ? '0 : v_cnt + CW'(1);

    h_in     = (CW'(h_cnt - X_BEG) < X_LEN);
    v_in     = (CW'(v_cnt - Y_BEG) < Y_LEN);
    h_in_nxt = (CW'(h_nxt - X_BEG) < X_LEN);
    v_in_nxt = (CW'(v_nxt - Y_BEG) < Y_LEN);

    // column replication: sx steps while staying inside the window
    sx_nxt   = sx;
    xpix_nxt = xpix;
    if (h_wrap) begin
      sx_nxt   = '0;
      xpix_nxt = '0;
    end else if (h_in && h_in_nxt) begin
      if (sx == SX_LAST) begin
        sx_nxt   = '0;
        xpix_nxt = xpix + XW'(1);
      end else begin
        sx_nxt   = sx + SW'(1);
      end
    end

    // row replication: sy steps at line wraps inside the window
    sy_nxt   = sy;
    ypix_nxt = ypix;
    if (h_wrap) begin
      if (v_wrap) begin
        sy_nxt   = '0;
        ypix_nxt = '0;
      end else if (v_in && v_in_nxt) begin
        if (sy == SY_LAST) begin
          sy_nxt   = '0;
          ypix_nxt = ypix + YW'(1);
        end else begin
          sy_nxt   = sy + SW'(1);
        end
      end
    end

    hpos_nxt = (h_in_nxt && v_in_nxt) ? xpix_nxt : '0;
    vpos_nxt = (h_in_nxt && v_in_nxt) ? ypix_nxt : '0;

    s0_de    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    s0_hs    = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    s0_vs    = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    s0_img   = h_in && v_in;
    s0_tick  = (h_cnt == '0) && (v_cnt == V_ACT);

    unique case (vram_pixelo)
      2'd0:    pal_c = 12'h000;
      2'd1:    pal_c = 12'h555;
      2'd2:    pal_c = 12'hAAA;
      default: pal_c = 12'hFFF;
    endcase
  end

  // counters, sub-counters and the VRAM address
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      sx        <= '0;
      sy        <= '0;
      xpix      <= '0;
      ypix      <= '0;
      vram_hpos <= '0;
      vram_vpos <= '0;
    end else begin
      h_cnt     <= h_nxt;
      v_cnt     <= v_nxt;
      sx        <= sx_nxt;
      sy        <= sy_nxt;
      xpix      <= xpix_nxt;
      ypix      <= ypix_nxt;
      vram_hpos <= hpos_nxt;
      vram_vpos <= vpos_nxt;
    end
  end

  // stage 1 holds timing while the VRAM read completes; stage 2 drives pins
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_hs      <= 1'b1;
      s1_vs      <= 1'b1;
      s1_de      <= 1'b0;
      s1_img     <= 1'b0;
      s1_tick    <= 1'b0;
      vga_hsync  <= 1'b1;
      vga_vsync  <= 1'b1;
      vga_de     <= 1'b0;
      vga_rgb    <= '0;
      frame_tick <= 1'b0;
    end else begin
      s1_hs      <= s0_hs;
      s1_vs      <= s0_vs;
      s1_de      <= s0_de;
      s1_img     <= s0_img;
      s1_tick    <= s0_tick;
      vga_hsync  <= s1_hs;
      vga_vsync  <= s1_vs;
      vga_de     <= s1_de;
      vga_rgb    <= (s1_de && s1_img) ? pal_c : '0;
      frame_tick <= s1_tick;
    end
  end

endmodule

// File: tb/tb_vram_scanout.sv
// Bench for vram_scanout on a shrunken timing/image geometry so whole frames
// fit in a short run. Expected outputs come from a per-position model of the
// raster (division-based pixel lookup) delayed by two clocks.
module tb_vram_scanout;

  localparam int H_ACT = 48, H_FP = 4, H_SW = 8, H_BP = 4;
  localparam int V_ACT = 24, V_FP = 3, V_SW = 2, V_BP = 3;
  localparam int HT = H_ACT + H_FP + H_SW + H_BP;
  localparam int VT = V_ACT + V_FP + V_SW + V_BP;
  localparam int SX = 3, SY = 3, XO = 12, YO = 4, IW = 12, IH = 5;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        tick;
    logic [11:0] rgb;
  } exp_t;

  localparam exp_t IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, tick: 1'b0, rgb: 12'h000};

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  vram_hpos;
  logic [5:0]  vram_vpos;
  logic [1:0]  vram_pixelo;
  logic        vga_hsync, vga_vsync, vga_de, frame_tick;
  logic [11:0] vga_rgb;

  always #5 clk = ~clk;

  vram_scanout #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SW), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SW), .V_BP(V_BP),
    .SCALE_X(SX), .SCALE_Y(SY), .X_OFF(XO), .Y_OFF(YO), .IMG_W(IW), .IMG_H(IH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .vram_hpos(vram_hpos), .vram_vpos(vram_vpos), .vram_pixelo(vram_pixelo),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .vga_de(vga_de),
    .vga_rgb(vga_rgb), .frame_tick(frame_tick)
  );

  logic [1:0] mem [0:127][0:63];
  exp_t       q[$];
  int         mh, mv, cyc, n_cmp, n_err;
  int         last_tick, rst_cyc, de_cnt;
  bit         tick_ref_valid, after_rst;
  logic [6:0] pa_x;
  logic [5:0] pa_y;

  function automatic logic [11:0] pal(input logic [1:0] p);
    case (p)
      2'd0:    return 12'h000;
      2'd1:    return 12'h555;
      2'd2:    return 12'hAAA;
      default: return 12'hFFF;
    endcase
  endfunction

  function automatic bit in_img(input int h, input int v);
    return (h >= XO) && (h < XO + IW * SX) && (v >= YO) && (v < YO + IH * SY);
  endfunction

  // What the pins should show for raster position (h,v)
  function automatic exp_t model(input int h, input int v);
    exp_t e;
    e.de   = (h < H_ACT) && (v < V_ACT);
    e.hs   = !((h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SW));
    e.vs   = !((v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SW));
    e.tick = (h == 0) && (v == V_ACT);
    e.rgb  = 12'h000;
    if (e.de && in_img(h, v)) e.rgb = pal(mem[(h - XO) / SX][(v - YO) / SY]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s cyc=%0d h=%0d v=%0d observed=%0h expected=%0h", tag, cyc, mh, mv, obs, expv);
    end
  endtask

  // One clock: drive reset for the coming edge, advance the model, compare,
  // then act as a 1-clk-latency VRAM for the address seen last cycle.
  task automatic clock(input logic rst_in);
    exp_t e;
    int   ax, ay;
    reset_n = ~rst_in;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_in) begin
      mh = 0;
      mv = 0;
      q.delete();
      q.push_back(IDLE);
      e = IDLE;
      rst_cyc = cyc;
      after_rst = 1'b1;
      tick_ref_valid = 1'b0;
    end else begin
      q.push_back(model(mh, mv));
      e = q.pop_front();
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv++;
        if (mv == VT) mv = 0;
      end
    end
    chk("hsync", 32'(vga_hsync), 32'(e.hs));
    chk("vsync", 32'(vga_vsync), 32'(e.vs));
    chk("de", 32'(vga_de), 32'(e.de));
    chk("rgb", 32'(vga_rgb), 32'(e.rgb));
    chk("frame_tick", 32'(frame_tick), 32'(e.tick));
    ax = in_img(mh, mv) ? (mh - XO) / SX : 0;
    ay = in_img(mh, mv) ? (mv - YO) / SY : 0;
    chk("vram_hpos", 32'(vram_hpos), 32'(ax));
    chk("vram_vpos", 32'(vram_vpos), 32'(ay));
    if (frame_tick === 1'b1) begin
      if (after_rst) begin
        chk("tick_after_reset", 32'(cyc - rst_cyc), 32'(V_ACT * HT + 2));
        after_rst = 1'b0;
      end else if (tick_ref_valid) begin
        chk("tick_period", 32'(cyc - last_tick), 32'(HT * VT));
      end
      last_tick = cyc;
      tick_ref_valid = 1'b1;
    end
    if (vga_de === 1'b1) de_cnt++;
    vram_pixelo = mem[pa_x][pa_y];
    pa_x = vram_hpos;
    pa_y = vram_vpos;
  endtask

  task automatic clear_mem();
    for (int x = 0; x < 128; x++)
      for (int y = 0; y < 64; y++) mem[x][y] = 2'd0;
  endtask

  initial begin
    int guard;
    reset_n = 1'b0;
    vram_pixelo = 2'd0;
    pa_x = '0;
    pa_y = '0;
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    mh = 0;
    mv = 0;
    tick_ref_valid = 1'b0;
    after_rst = 1'b0;
    clear_mem();

    // Single bright pixel at the image origin; reset outputs, first frames
    repeat (3) clock(1'b1);
    mem[0][0] = 2'd3;
    repeat (2 * HT * VT + 100) clock(1'b0);

    // Bottom-right image pixel only, preceded by a fresh reset
    clear_mem();
    mem[IW - 1][IH - 1] = 2'd2;
    repeat (2) clock(1'b1);
    repeat (HT * VT + 50) clock(1'b0);

    // Checkerboard 1/2; count visible pixels over exactly one frame period
    for (int x = 0; x < 128; x++)
      for (int y = 0; y < 64; y++) mem[x][y] = ((x ^ y) & 1) ? 2'd2 : 2'd1;
    clock(1'b1);
    de_cnt = 0;
    repeat (HT * VT) clock(1'b0);
    chk("de_per_frame", 32'(de_cnt), 32'(H_ACT * V_ACT));

    // Random image, 1-clk reset in the middle of a visible line
    for (int x = 0; x < 128; x++)
      for (int y = 0; y < 64; y++) mem[x][y] = 2'($urandom_range(0, 3));
    guard = 0;
    while (!(mh == H_ACT / 2 + 8 && mv == V_ACT / 2) && guard < 2 * HT * VT) begin
      clock(1'b0);
      guard++;
    end
    chk("reach_mid_frame", 32'(guard < 2 * HT * VT), 32'd1);
    clock(1'b1);
    repeat (V_ACT * HT + HT * VT + 200) clock(1'b0);

    // Reset at a random point, then CPU-style writes while scanning
    repeat ($urandom_range(1, HT * VT)) clock(1'b0);
    repeat (2) clock(1'b1);
    repeat (500) clock(1'b0);
    for (int i = 0; i < 40; i++)
      mem[$urandom_range(0, IW - 1)][$urandom_range(0, IH - 1)] = 2'($urandom_range(0, 3));
    repeat (2 * HT * VT) clock(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
